// File: rtl/fifo_word_serializer.sv
// Pops WIDTH-bit words from a show-ahead FIFO and streams each one out as
// WIDTH/OUT_W narrow beats on a valid/ready interface, chaining words without bubbles.
module fifo_word_serializer #(
    parameter int WIDTH     = 256,
    parameter int OUT_W     = 32,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_out
);

    localparam int BEATS = WIDTH / OUT_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [BEATS-1:0][OUT_W-1:0] hold;
    logic [BCW-1:0]              beat_cnt;
    logic [BCW-1:0]              lane_idx;
    logic                        beat_is_last;
    logic                        xfer;

    assign beat_is_last = (beat_cnt == BCW'(BEATS - 1));
    assign lane_idx     = (MSB_FIRST != 0) ? (BCW'(BEATS - 1) - beat_cnt) : beat_cnt;
    assign out_data     = hold[lane_idx];
    assign xfer         = out_valid && out_ready;

    // The pop strobe is combinational so the next word is taken on the same
    // edge that retires the last beat, which is what keeps words back-to-back.
    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && !fifo_empty) begin
                    fifo_rd   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = beat_is_last;
                if (out_ready && beat_is_last) begin
                    if (!fifo_empty) begin
                        fifo_rd = !rst;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pop always restarts the lane walk; otherwise the counter only moves on
    // an accepted beat, so a stalled beat stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            beat_cnt  <= '0;
            words_out <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_rd) begin
                hold     <= fifo_rd_data;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_is_last ? '0 : beat_cnt + 1'b1;
            end
            if (xfer && beat_is_last) begin
                words_out <= words_out + 1'b1;
            end
        end
    end

endmodule
